pipe_stage_frame: RTL and testbench
===================================

PIPE_STAGE_FRAME -- requirements
Module: pipe_stage_frame

Interface
REQ-001 SHALL have parameter LANE_WIDTH, default 32, bit width of one data lane (one operand/field slot).
REQ-002 SHALL have parameter LANES, default 4, number of independently write-enabled data lanes.
REQ-003 SHALL have parameter CTRL_WIDTH, default 8, width of control bundle (write-enable, pc-overwrite, branch, jump bits) that must never leak from a bubble.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port flush  input  1  discard all held frames (branch/jump redirect).
REQ-007 SHALL have port in_valid  input  1  upstream frame present.
REQ-008 SHALL have port in_ready  output  1  stage can accept a frame this cycle.
REQ-009 SHALL have port in_data  input  LANES*LANE_WIDTH  lane i at bits [i*LANE_WIDTH +: LANE_WIDTH].
REQ-010 SHALL have port in_lane_we  input  LANES  per-lane update mask for the incoming frame.
REQ-011 SHALL have port in_ctrl  input  CTRL_WIDTH  control bundle of incoming frame.
REQ-012 SHALL have port out_valid  output  1  frame presented downstream.
REQ-013 SHALL have port out_ready  input  1  downstream accepts this cycle.
REQ-014 SHALL have port out_data  output  LANES*LANE_WIDTH  presented frame data.
REQ-015 SHALL have port out_ctrl  output  CTRL_WIDTH  presented control; all-zero whenever out_valid=0.
REQ-016 SHALL have port occupancy  output  2  frames held (0, 1 or 2).

Function
REQ-017 SHALL hold two entries: main (drives out_*) and skid; frames leave in acceptance order.
REQ-018 SHALL accept a frame when in_valid && in_ready; drain main when out_valid && out_ready.
REQ-019 SHALL drive in_ready = !skid_valid && !flush && !reset (combinational from flush/reset, registered otherwise).
REQ-020 SHALL keep a shadow register holding the last accepted merged frame data; merged lane i = in_lane_we[i] ? in_data lane i : shadow lane i; shadow updated with merged data on every accept.
REQ-021 SHALL store merged data and in_ctrl unmodified into the target entry on accept.
REQ-022 SHALL present an accepted frame on out_* the cycle after acceptance when main was empty or draining (latency 1).
REQ-023 Main empty or draining, skid empty, accept: frame goes to main.
REQ-024 Main full and not draining, accept: frame goes to skid; in_ready drops next cycle.
REQ-025 Skid full and main draining: skid moves to main next cycle; in_ready rises next cycle.
REQ-026 Accept and drain in same cycle with skid empty: main replaced, occupancy unchanged.
REQ-027 out_valid=1 SHALL hold out_data/out_ctrl stable until drained (no change while out_ready=0).
REQ-028 flush SHALL clear main and skid valid, force out_ctrl to zero the next cycle and occupancy to 0; an offered frame in the flush cycle is not accepted; shadow retained.
REQ-029 flush SHALL take priority over simultaneous accept and drain; a drain in the flush cycle still counts as consumed by downstream.
REQ-030 occupancy SHALL equal main_valid + skid_valid, registered.

Reset
REQ-031 On reset: out_valid=0, out_data=0, out_ctrl=0, occupancy=0, skid cleared, shadow=0; in_ready=0 while reset high, 1 the first cycle after release.
REQ-032 Reset mid-operation SHALL discard held frames with no output in the following cycle.

Verification
REQ-033 Reset release, in_valid=1 data lanes {1,2,3,4}, we=4'b1111, ctrl=8'h81, out_ready=1 -> next cycle out_valid=1, out_data lanes {1,2,3,4}, out_ctrl=8'h81.
REQ-034 After REQ-033, frame lanes {9,9,9,9} we=4'b0101 -> output lanes {9,2,9,4} (lane 0 = bit 0).
REQ-035 out_ready=0, two frames A, B accepted back-to-back -> occupancy 2, in_ready=0, out shows A; out_ready=1 -> A drains, B next cycle, in_ready=1.
REQ-036 occupancy 2, flush=1 with in_valid=1 -> next cycle occupancy 0, out_valid=0, out_ctrl=0, offered frame absent afterward.
REQ-037 Continuous in_valid=1/out_ready=1 for 16 frames -> one frame per cycle, no stall, order preserved.
REQ-038 Random in_valid/out_ready/flush for 10k cycles vs reference queue model -> no loss, duplication or reorder; out_ctrl=0 whenever out_valid=0.

Source files
------------

// File: rtl/pipe_stage_frame.sv
// Purpose    : two-entry (main + skid) frame pipeline stage with per-lane write
//              merge against a shadow copy of the last accepted frame.
// Latency    : 1 cycle from accept to out_valid when main is empty or draining.
// Backpressure: in_ready drops once the skid entry is occupied; the skid entry
//              absorbs the frame offered in the cycle where downstream stalls.
// Ports:
//   clk, reset (sync, active-high), flush (drop all held frames)
//   in_valid/in_ready/in_data/in_lane_we/in_ctrl : upstream frame handshake
//   out_valid/out_ready/out_data/out_ctrl        : downstream frame handshake
//   occupancy                                    : frames held (0..2)
module pipe_stage_frame #(
    parameter int LANE_WIDTH = 32,
    parameter int LANES      = 4,
    parameter int CTRL_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*LANE_WIDTH-1:0] in_data,
    input  logic [LANES-1:0]            in_lane_we,
    input  logic [CTRL_WIDTH-1:0]       in_ctrl,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*LANE_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0]       out_ctrl,
    output logic [1:0]                  occupancy
);

    localparam int DW = LANES * LANE_WIDTH;

    typedef struct packed {
        logic [CTRL_WIDTH-1:0] ctrl;
        logic [DW-1:0]         data;
    } frame_t;

    logic          r_main_vld;
    logic          r_skid_vld;
    frame_t        r_main;
    frame_t        r_skid;
    logic [DW-1:0] r_shadow;
    logic [1:0]    r_occ;

    logic          w_accept;
    logic          w_drain;
    logic [DW-1:0] w_merged;
    frame_t        w_in_frame;
    logic          w_main_vld_nxt;
    logic          w_skid_vld_nxt;
    frame_t        w_main_nxt;
    frame_t        w_skid_nxt;

    // Skid occupancy is the only registered term; flush and reset block
    // acceptance in the same cycle they are asserted.
    assign in_ready = !r_skid_vld && !flush && !reset;
    assign w_accept = in_valid && in_ready;
    assign w_drain  = r_main_vld && out_ready;

    // Lanes not written by this frame inherit the previous accepted frame.
    always_comb begin
        w_merged = r_shadow;
        for (int i = 0; i < LANES; i++) begin
            if (in_lane_we[i]) begin
                w_merged[i*LANE_WIDTH +: LANE_WIDTH] = in_data[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    assign w_in_frame.ctrl = in_ctrl;
    assign w_in_frame.data = w_merged;

    // Skid only fills while main is held, so a full skid implies a full main
    // and refills main on the drain that frees it.
    always_comb begin
        w_main_vld_nxt = r_main_vld;
        w_skid_vld_nxt = r_skid_vld;
        w_main_nxt     = r_main;
        w_skid_nxt     = r_skid;
        if (flush) begin
            w_main_vld_nxt = 1'b0;
            w_skid_vld_nxt = 1'b0;
        end else if (!r_main_vld || w_drain) begin
            if (r_skid_vld) begin
                w_main_nxt     = r_skid;
                w_main_vld_nxt = 1'b1;
                w_skid_vld_nxt = 1'b0;
            end else if (w_accept) begin
                w_main_nxt     = w_in_frame;
                w_main_vld_nxt = 1'b1;
            end else begin
                w_main_vld_nxt = 1'b0;
            end
        end else if (w_accept) begin
            w_skid_nxt     = w_in_frame;
            w_skid_vld_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
            r_main     <= '0;
            r_skid     <= '0;
            r_shadow   <= '0;
            r_occ      <= 2'd0;
        end else begin
            r_main_vld <= w_main_vld_nxt;
            r_skid_vld <= w_skid_vld_nxt;
            r_main     <= w_main_nxt;
            r_skid     <= w_skid_nxt;
            r_occ      <= {1'b0, w_main_vld_nxt} + {1'b0, w_skid_vld_nxt};
            if (w_accept) begin
                r_shadow <= w_merged;
            end
        end
    end

    assign out_valid = r_main_vld;
    assign out_data  = r_main.data;
    // A bubble must never present control bits, even if stale ones remain held.
    assign out_ctrl  = r_main.ctrl & {CTRL_WIDTH{r_main_vld}};
    assign occupancy = r_occ;

endmodule

// File: tb/tb_pipe_stage_frame.sv
// Bench for pipe_stage_frame: directed vector table followed by streaming and
// randomized traffic compared against a queue-based frame model.
module tb_pipe_stage_frame;

    localparam int LW = 32;
    localparam int NL = 4;
    localparam int CW = 8;
    localparam int DW = LW * NL;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [NL-1:0] in_lane_we;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [1:0]    occupancy;

    pipe_stage_frame #(.LANE_WIDTH(LW), .LANES(NL), .CTRL_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_lane_we(in_lane_we), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ctrl(out_ctrl), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mk(input int a, input int b, input int c, input int d);
        logic [DW-1:0] v;
        v = '0;
        v[0*LW +: LW] = LW'(a);
        v[1*LW +: LW] = LW'(b);
        v[2*LW +: LW] = LW'(c);
        v[3*LW +: LW] = LW'(d);
        return v;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          rst;
        logic          fl;
        logic          vld;
        logic [DW-1:0] dat;
        logic [NL-1:0] we;
        logic [CW-1:0] ctl;
        logic          ordy;
        logic          e_vld;
        logic          e_chkdat;
        logic [DW-1:0] e_dat;
        logic [CW-1:0] e_ctl;
        logic [1:0]    e_occ;
        logic          e_irdy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic fl, input logic vld, input logic [DW-1:0] dat,
                       input logic [NL-1:0] we, input logic [CW-1:0] ctl, input logic ordy,
                       input logic e_vld, input logic e_chkdat, input logic [DW-1:0] e_dat,
                       input logic [CW-1:0] e_ctl, input logic [1:0] e_occ, input logic e_irdy);
        vec_t v;
        v.rst = rst; v.fl = fl; v.vld = vld; v.dat = dat; v.we = we; v.ctl = ctl; v.ordy = ordy;
        v.e_vld = e_vld; v.e_chkdat = e_chkdat; v.e_dat = e_dat; v.e_ctl = e_ctl;
        v.e_occ = e_occ; v.e_irdy = e_irdy;
        vecs.push_back(v);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [DW-1:0] dat;
        logic [CW-1:0] ctl;
    } frm_t;

    frm_t          mq[$];
    logic [DW-1:0] m_shadow;
    int            dut_drained;

    task automatic mstep(input logic rst, input logic fl, input logic v, input logic [DW-1:0] d,
                         input logic [NL-1:0] we, input logic [CW-1:0] c, input logic ordy);
        logic e_vld, e_irdy, acc, drn;
        frm_t f;
        @(negedge clk);
        reset = rst; flush = fl; in_valid = v; in_data = d; in_lane_we = we; in_ctrl = c;
        out_ready = ordy;
        #1;
        e_vld  = (mq.size() != 0);
        e_irdy = (mq.size() < 2) && !fl && !rst;
        chk("m_out_valid", DW'(out_valid), DW'(e_vld));
        chk("m_occupancy", DW'(occupancy), DW'(mq.size()));
        chk("m_in_ready", DW'(in_ready), DW'(e_irdy));
        chk("m_out_ctrl", DW'(out_ctrl), e_vld ? DW'(mq[0].ctl) : '0);
        if (e_vld) chk("m_out_data", out_data, mq[0].dat);
        if (out_valid && out_ready) dut_drained++;
        @(posedge clk);
        acc = v && e_irdy;
        drn = e_vld && ordy;
        if (rst) begin
            mq.delete();
            m_shadow = '0;
        end else if (fl) begin
            mq.delete();
        end else begin
            if (drn) void'(mq.pop_front());
            if (acc) begin
                for (int i = 0; i < NL; i++)
                    if (we[i]) m_shadow[i*LW +: LW] = d[i*LW +: LW];
                f.dat = m_shadow;
                f.ctl = c;
                mq.push_back(f);
            end
        end
    endtask

    initial begin
        int stalls;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_lane_we = '0;
        in_ctrl = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);

        //   rst fl vld data            we       ctl    ordy | vld chk  data                ctl    occ irdy
        add(1, 0, 0, '0,               4'h0, 8'h00, 0,  0, 1, '0,               8'h00, 0, 0);
        add(0, 0, 1, mk(1,2,3,4),      4'hF, 8'h81, 1,  0, 1, '0,               8'h00, 0, 1);
        add(0, 0, 1, mk(9,9,9,9),      4'h5, 8'h02, 1,  1, 1, mk(1,2,3,4),      8'h81, 1, 1);
        add(0, 0, 0, '0,               4'h0, 8'h00, 1,  1, 1, mk(9,2,9,4),      8'h02, 1, 1);
        add(0, 0, 1, mk(10,11,12,13),  4'hF, 8'h0A, 0,  0, 0, '0,               8'h00, 0, 1);
        add(0, 0, 1, mk(20,21,22,23),  4'hF, 8'h0B, 0,  1, 1, mk(10,11,12,13),  8'h0A, 1, 1);
        add(0, 0, 1, mk(30,31,32,33),  4'hF, 8'h0C, 0,  1, 1, mk(10,11,12,13),  8'h0A, 2, 0);
        add(0, 0, 0, '0,               4'h0, 8'h00, 0,  1, 1, mk(10,11,12,13),  8'h0A, 2, 0);
        add(0, 0, 0, '0,               4'h0, 8'h00, 1,  1, 1, mk(10,11,12,13),  8'h0A, 2, 0);
        add(0, 0, 0, '0,               4'h0, 8'h00, 0,  1, 1, mk(20,21,22,23),  8'h0B, 1, 1);
        add(0, 0, 1, mk(40,41,42,43),  4'hF, 8'h0D, 0,  1, 1, mk(20,21,22,23),  8'h0B, 1, 1);
        add(0, 1, 1, mk(50,51,52,53),  4'hF, 8'h0E, 1,  1, 1, mk(20,21,22,23),  8'h0B, 2, 0);
        add(0, 0, 0, '0,               4'h0, 8'h00, 1,  0, 0, '0,               8'h00, 0, 1);
        add(0, 0, 0, '0,               4'h0, 8'h00, 1,  0, 0, '0,               8'h00, 0, 1);
        add(0, 0, 1, mk(7,7,7,7),      4'h2, 8'h33, 1,  0, 0, '0,               8'h00, 0, 1);
        add(0, 0, 0, '0,               4'h0, 8'h00, 0,  1, 1, mk(40,7,42,43),   8'h33, 1, 1);
        add(1, 0, 1, mk(8,8,8,8),      4'hF, 8'h44, 0,  1, 1, mk(40,7,42,43),   8'h33, 1, 0);
        add(0, 0, 0, '0,               4'h0, 8'h00, 1,  0, 1, '0,               8'h00, 0, 1);
        add(0, 0, 1, mk(5,5,5,5),      4'h1, 8'h01, 1,  0, 1, '0,               8'h00, 0, 1);
        add(0, 0, 0, '0,               4'h0, 8'h00, 1,  1, 1, mk(5,0,0,0),      8'h01, 1, 1);

        foreach (vecs[k]) begin
            @(negedge clk);
            reset = vecs[k].rst; flush = vecs[k].fl; in_valid = vecs[k].vld;
            in_data = vecs[k].dat; in_lane_we = vecs[k].we; in_ctrl = vecs[k].ctl;
            out_ready = vecs[k].ordy;
            #1;
            chk($sformatf("v%0d_out_valid", k), DW'(out_valid), DW'(vecs[k].e_vld));
            chk($sformatf("v%0d_out_ctrl", k), DW'(out_ctrl), DW'(vecs[k].e_ctl));
            chk($sformatf("v%0d_occupancy", k), DW'(occupancy), DW'(vecs[k].e_occ));
            chk($sformatf("v%0d_in_ready", k), DW'(in_ready), DW'(vecs[k].e_irdy));
            if (vecs[k].e_chkdat) chk($sformatf("v%0d_out_data", k), out_data, vecs[k].e_dat);
        end

        // Bring DUT and model to a common empty state.
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0;
        @(posedge clk);
        mq.delete();
        m_shadow = '0;

        // Streaming: one frame per cycle with no stall.
        mstep(1, 0, 0, '0, '0, '0, 0);
        dut_drained = 0;
        stalls = 0;
        for (int i = 0; i < 16; i++) begin
            mstep(0, 0, 1, mk(100 + i, 200 + i, 300 + i, 400 + i), 4'hF, CW'(i + 1), 1);
            if (!in_ready) stalls++;
        end
        mstep(0, 0, 0, '0, '0, '0, 1);
        chk("stream_stalls", DW'(stalls), '0);
        chk("stream_drained", DW'(dut_drained), DW'(16));

        // Randomized traffic, including partial lane writes, flush and reset.
        for (int i = 0; i < 10000; i++) begin
            logic r, f, v, o;
            logic [DW-1:0] d;
            r = ($urandom_range(0, 199) == 0);
            f = ($urandom_range(0, 31) == 0);
            v = ($urandom_range(0, 9) < 7);
            o = ($urandom_range(0, 9) < 6);
            for (int j = 0; j < NL; j++) d[j*LW +: LW] = $urandom;
            mstep(r, f, v, d, NL'($urandom), CW'($urandom), o);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
